image_row_reader: RTL and testbench

IMAGE_ROW_READER -- requirements
Module: image_row_reader

---
 rtl/image_pkg.sv | 18 +
 rtl/image_skid_buf.sv | 52 +++++
 rtl/image_row_reader.sv | 140 ++++++++++++++
 tb/tb_image_row_reader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared definitions for the image row reader: FSM encoding, holdoff length
// and output buffer depth.
package image_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ROW = 2'd1,
        ST_READ_ROW = 2'd2,
        ST_FINISH   = 2'd3
    } state_t;

    // Cycles during which M_Ready is ignored after its threshold or occupancy changes.
    localparam int HOLDOFF_CYCLES = 2;
    localparam int HOLDOFF_BITS   = 2;

    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/image_skid_buf.sv
// Two-entry output buffer with registered head; the head only changes on a
// pop or when the buffer is empty, so data holds steady while stalled.
module image_skid_buf
    import image_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [1:0]       count
);

    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic [1:0] wr_idx;

    // A push lands in the slot left free after this cycle's pop.
    assign wr_idx     = count_reg - {1'b0, pop};
    assign count_next = wr_idx + {1'b0, push};

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                entry_reg <= '0;
            end else if (push && wr_idx == 2'(gi)) begin
                entry_reg <= push_data;
            end else if (pop && count_reg == 2'(BUF_DEPTH) && gi < BUF_DEPTH - 1) begin
                entry_reg <= g_entry[(gi + 1) % BUF_DEPTH].entry_reg;
            end
        end
    end

    assign out_data  = g_entry[0].entry_reg;
    assign out_valid = (count_reg != 2'd0);
    assign count     = count_reg;

endmodule

// File: rtl/image_row_reader.sv
// Reads an image frame row by row from a FIFO once a full row is available
// and streams it downstream with a per-row last flag and a frame done pulse.
module image_row_reader
    import image_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 10,
    parameter int ROW_BITS  = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS:0]   row_len,
    input  logic [ROW_BITS-1:0]  row_num,
    output logic [ADDR_BITS:0]   M_count,
    input  logic                 M_Ready,
    output logic                 rd_en,
    input  logic [WIDTH-1:0]     fifo_dout,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = ADDR_BITS + 1;

    state_t                  state_reg;
    state_t                  state_next;
    logic [CNT_W-1:0]        row_len_reg;
    logic [CNT_W-1:0]        col_cnt_reg;
    logic [ROW_BITS-1:0]     row_num_reg;
    logic [ROW_BITS-1:0]     row_cnt_reg;
    logic [HOLDOFF_BITS-1:0] holdoff_reg;
    logic                    inflight_reg;
    logic                    inflight_last_reg;

    logic [1:0]  buf_count;
    logic [WIDTH:0] buf_out;
    logic        buf_valid;
    logic        pop;
    logic        last_col;
    logic        last_row;
    logic [2:0]  pending;

    assign pop = buf_valid & m_ready;
    // Occupancy is counted after this cycle's pop so a steady stream keeps 1 word/cycle.
    assign pending  = {1'b0, buf_count} - {2'b0, pop} + {2'b0, inflight_reg};
    assign last_col = (col_cnt_reg == row_len_reg - CNT_W'(1));
    assign last_row = (row_cnt_reg == row_num_reg - ROW_BITS'(1));
    assign rd_en    = (state_reg == ST_READ_ROW) && (pending < 3'd2);

    always_comb begin
        state_next = state_reg;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_WAIT_ROW;
            end
            ST_WAIT_ROW: begin
                if (M_Ready && holdoff_reg == '0) state_next = ST_READ_ROW;
            end
            ST_READ_ROW: begin
                if (rd_en && last_col) state_next = last_row ? ST_FINISH : ST_WAIT_ROW;
            end
            ST_FINISH: begin
                if (!buf_valid && !inflight_reg) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            row_len_reg       <= '0;
            row_num_reg       <= '0;
            col_cnt_reg       <= '0;
            row_cnt_reg       <= '0;
            holdoff_reg       <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            inflight_reg      <= rd_en;
            inflight_last_reg <= rd_en & last_col;
            case (state_reg)
                ST_IDLE: begin
                    // M_count changes here too, so the FIFO flag is stale at frame start as well.
                    if (start) begin
                        row_len_reg <= row_len;
                        row_num_reg <= row_num;
                        col_cnt_reg <= '0;
                        row_cnt_reg <= '0;
                        holdoff_reg <= HOLDOFF_BITS'(HOLDOFF_CYCLES);
                    end
                end
                ST_WAIT_ROW: begin
                    if (holdoff_reg != '0) holdoff_reg <= holdoff_reg - HOLDOFF_BITS'(1);
                end
                ST_READ_ROW: begin
                    if (rd_en) begin
                        if (last_col) begin
                            col_cnt_reg <= '0;
                            row_cnt_reg <= row_cnt_reg + ROW_BITS'(1);
                            holdoff_reg <= HOLDOFF_BITS'(HOLDOFF_CYCLES);
                        end else begin
                            col_cnt_reg <= col_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    image_skid_buf #(
        .WIDTH(WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_reg),
        .push_data ({inflight_last_reg, fifo_dout}),
        .pop       (pop),
        .out_data  (buf_out),
        .out_valid (buf_valid),
        .count     (buf_count)
    );

    assign m_data  = buf_out[WIDTH-1:0];
    assign m_valid = buf_valid;
    assign m_last  = buf_valid & buf_out[WIDTH];
    assign M_count = row_len_reg;
    assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_image_row_reader.sv
// Self-checking bench for image_row_reader: FIFO model with registered
// M_Ready, scoreboard of expected pixels, directed and random frames.
module tb_image_row_reader;

    localparam int WIDTH     = 8;
    localparam int ADDR_BITS = 10;
    localparam int ROW_BITS  = 11;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [ADDR_BITS:0]  row_len = '0;
    logic [ROW_BITS-1:0] row_num = '0;
    logic [ADDR_BITS:0]  M_count;
    logic                M_Ready = 1'b0;
    logic                rd_en;
    logic [WIDTH-1:0]    fifo_dout = '0;
    logic [WIDTH-1:0]    m_data;
    logic                m_valid;
    logic                m_ready = 1'b1;
    logic                m_last;
    logic                busy;
    logic                done;

    always #5 clk = ~clk;

    image_row_reader #(
        .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .ROW_BITS(ROW_BITS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .row_len(row_len), .row_num(row_num),
        .M_count(M_count), .M_Ready(M_Ready), .rd_en(rd_en), .fifo_dout(fifo_dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // FIFO model: registered count, flag registered from that count, 1-cycle read latency.
    logic [7:0]         fifo_q[$];
    logic [7:0]         src_q[$];
    logic [8:0]         exp_q[$];
    int                 fifo_cnt = 0;
    logic               rd_s = 1'b0;
    logic [ADDR_BITS:0] mcount_s = '0;

    always @(negedge clk) begin
        rd_s     <= rd_en;
        mcount_s <= M_count;
    end

    always @(posedge clk) begin
        M_Ready <= (mcount_s != 0) && (fifo_cnt >= int'(mcount_s));
        if (rd_s) begin
            check_eq("fifo_has_data_on_rd", 32'(fifo_q.size() > 0), 1);
            if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
        end
        fifo_cnt <= fifo_q.size();
    end

    bit ready_rand = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard, stall hold, done pulse and event timestamps.
    int         cyc = 0;
    int         done_cnt = 0;
    int         xfer_cnt = 0;
    int         mr_rise_cyc = -1;
    int         rd_rise_cyc = -1;
    int         val_rise_cyc = -1;
    int         xfer_rise_cyc = -1;
    int         last_xfer_cyc = -1;
    bit         prev_stall = 1'b0;
    bit         prev_done = 1'b0;
    bit         prev_mr = 1'b0;
    bit         prev_rd = 1'b0;
    bit         prev_val = 1'b0;
    bit         prev_xfer = 1'b0;
    logic [7:0] prev_data = '0;
    logic [8:0] mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
            prev_xfer  = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid_held", 32'(m_valid), 1);
                check_eq("stall_data_held", 32'(m_data), 32'(prev_data));
            end
            if (!m_valid) check_eq("last_without_valid", 32'(m_last), 0);
            if (m_valid && m_ready) begin
                xfer_cnt++;
                if (!prev_xfer) xfer_rise_cyc = cyc;
                last_xfer_cyc = cyc;
                check_eq("xfer_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check_eq("pixel_data", 32'(m_data), 32'(mon_e[7:0]));
                    check_eq("pixel_last", 32'(m_last), 32'(mon_e[8]));
                end
            end
            if (done) begin
                done_cnt++;
                check_eq("done_one_cycle", 32'(prev_done), 0);
            end
            if (M_Ready && !prev_mr) mr_rise_cyc = cyc;
            if (rd_en && !prev_rd) rd_rise_cyc = cyc;
            if (m_valid && !prev_val) val_rise_cyc = cyc;
            prev_stall = m_valid && !m_ready;
            prev_xfer  = m_valid && m_ready;
            prev_data  = m_data;
            prev_done  = done;
        end
        prev_mr  = M_Ready;
        prev_rd  = rd_en;
        prev_val = m_valid;
    end

    // Reference: pixel i of the frame is tagged last when i mod row_len is row_len-1.
    task automatic load_frame(input int len, input int rows, input bit seq, input int preload);
        for (int i = 0; i < len * rows; i++) begin
            logic [7:0] d;
            d = seq ? 8'(i) : 8'($urandom);
            exp_q.push_back({((i % len) == len - 1), d});
            if (i < preload) fifo_q.push_back(d);
            else src_q.push_back(d);
        end
    endtask

    task automatic pulse_start(input int len, input int rows);
        @(posedge clk);
        #1;
        start   = 1'b1;
        row_len = (ADDR_BITS + 1)'(len);
        row_num = ROW_BITS'(rows);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic flush_model();
        fifo_q.delete();
        src_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            if (src_q.size() > 0 && $urandom_range(0, 2) != 0) fifo_q.push_back(src_q.pop_front());
        end
        check_eq({tag, "_done_seen"}, 32'(done_cnt != d0), 1);
        repeat (4) @(negedge clk);
        #1;
        check_eq({tag, "_done_once"}, 32'(done_cnt - d0), 1);
        check_eq({tag, "_drained"}, 32'(exp_q.size()), 0);
        check_eq({tag, "_idle"}, 32'(busy), 0);
        $display("[TB] frame %s finished after %0d cycles", tag, n);
        flush_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rd_en"}, 32'(rd_en), 0);
        check_eq({tag, "_m_valid"}, 32'(m_valid), 0);
        check_eq({tag, "_m_last"}, 32'(m_last), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_M_count"}, 32'(M_count), 0);
        check_eq({tag, "_m_data"}, 32'(m_data), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int x0;
        int d0;
        int n;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two rows of 4 from a preloaded FIFO, sequential data.
        load_frame(4, 2, 1'b1, 8);
        pulse_start(4, 2);
        check_eq("mcount_latched", 32'(M_count), 4);
        wait_done(200, "seq8");

        // Only 3 of 4 words present; 4th arrives later.
        load_frame(4, 1, 1'b1, 3);
        rd0 = rd_rise_cyc;
        pulse_start(4, 1);
        repeat (5) @(negedge clk);
        #1;
        check_eq("no_rd_before_ready", 32'(rd_rise_cyc == rd0), 1);
        check_eq("mready_low_3_words", 32'(M_Ready), 0);
        fifo_q.push_back(src_q.pop_front());
        wait_done(200, "late4");
        check_eq("rd_latency", 32'(rd_rise_cyc - mr_rise_cyc), 1);
        check_eq("valid_latency", 32'(val_rise_cyc - rd_rise_cyc), 2);

        // Random downstream stalls.
        ready_rand = 1'b1;
        load_frame(8, 1, 1'b0, 8);
        pulse_start(8, 1);
        wait_done(400, "stall8");
        ready_rand = 1'b0;

        // Maximum row length, streaming at full rate.
        load_frame(1024, 1, 1'b0, 1024);
        pulse_start(1024, 1);
        wait_done(3000, "row1024");
        check_eq("throughput_span", 32'(last_xfer_cyc - xfer_rise_cyc), 1023);

        // Reset after 3 of 8 pixels.
        load_frame(8, 1, 1'b0, 8);
        x0 = xfer_cnt;
        pulse_start(8, 1);
        n = 0;
        while (xfer_cnt - x0 < 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("midrst_three_xfers", 32'(xfer_cnt - x0), 3);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outputs("midrst");
        d0 = done_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush_model();
        repeat (20) @(negedge clk);
        #1;
        check_eq("no_done_after_rst", 32'(done_cnt - d0), 0);
        load_frame(2, 2, 1'b1, 4);
        pulse_start(2, 2);
        wait_done(200, "restart");

        // Start while busy must not disturb the running frame.
        load_frame(4, 2, 1'b0, 8);
        pulse_start(4, 2);
        repeat (2) @(posedge clk);
        #1;
        start   = 1'b1;
        row_len = (ADDR_BITS + 1)'(2);
        row_num = ROW_BITS'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("mcount_kept", 32'(M_count), 4);
        wait_done(300, "busy_start");

        // Random frames with trickling writes and random stalls.
        for (int k = 0; k < 6; k++) begin
            int len;
            int rows;
            len        = $urandom_range(1, 12);
            rows       = $urandom_range(1, 3);
            ready_rand = 1'($urandom_range(0, 1));
            load_frame(len, rows, 1'b0, $urandom_range(0, len * rows));
            pulse_start(len, rows);
            wait_done(2000, "rand");
        end
        ready_rand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
